podule_bus: RTL and testbench



---
 rtl/podule_pkg.sv | 21 ++
 rtl/podule_irq_agg.sv | 43 ++++
 rtl/podule_bus.sv | 189 ++++++++++++++++++
 tb/tb_podule_bus.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/podule_pkg.sv
// Shared types and constants for the podule expansion-bus controller.
package podule_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ACK  = 2'b10,
        HOLD = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SPD_SLOW = 2'b00,
        SPD_MED  = 2'b01,
        SPD_FAST = 2'b10,
        SPD_SYNC = 2'b11
    } speed_e;

    localparam logic [15:0] FLOAT_DATA = 16'hFFFF;
    localparam int unsigned SLOT_W     = 2;

endpackage

// File: rtl/podule_irq_agg.sv
// Registered per-slot IRQ/FIQ masking by slot presence and OR aggregation.
module podule_irq_agg
    import podule_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4
) (
    input  logic                 clkcpu,
    input  logic                 rst_n,
    input  logic [NUM_SLOTS-1:0] slot_irq,
    input  logic [NUM_SLOTS-1:0] slot_firq,
    input  logic [NUM_SLOTS-1:0] slot_present,
    output logic                 irq_o,
    output logic                 firq_o,
    output logic [NUM_SLOTS-1:0] irq_status
);

    logic [NUM_SLOTS-1:0] status_d, status_q;
    logic                 irq_d, irq_q;
    logic                 firq_d, firq_q;

    always_comb begin
        status_d = slot_irq & slot_present;
        irq_d    = |(slot_irq & slot_present);
        firq_d   = |(slot_firq & slot_present);
    end

    always_ff @(posedge clkcpu) begin
        if (!rst_n) begin
            status_q <= '0;
            irq_q    <= 1'b0;
            firq_q   <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_q    <= irq_d;
            firq_q   <= firq_d;
        end
    end

    assign irq_status = status_q;
    assign irq_o      = irq_q;
    assign firq_o     = firq_q;

endmodule

// File: rtl/podule_bus.sv
// Podule bus controller: per-slot select/mux/ack with speed-dependent minimum
// access time, timeout with float-high read, abort handling and IRQ aggregation.
module podule_bus
    import podule_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned DW        = 16,
    parameter int unsigned SLOW_CYC  = 8,
    parameter int unsigned MED_CYC   = 6,
    parameter int unsigned FAST_CYC  = 4,
    parameter int unsigned SYNC_CYC  = 2,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                    clkcpu,
    input  logic                    rst_n,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [13:0]             wb_adr,
    input  logic [1:0]              wb_speed,
    input  logic [DW-1:0]           wb_dat_i,
    output logic [DW-1:0]           wb_dat_o,
    output logic                    wb_ack,
    output logic [NUM_SLOTS-1:0]    slot_sel,
    output logic                    slot_we,
    output logic [11:0]             slot_adr,
    output logic [DW-1:0]           slot_dat_o,
    input  logic [NUM_SLOTS*DW-1:0] slot_dat_i,
    input  logic [NUM_SLOTS-1:0]    slot_ack,
    input  logic [NUM_SLOTS-1:0]    slot_present,
    input  logic [NUM_SLOTS-1:0]    slot_irq,
    input  logic [NUM_SLOTS-1:0]    slot_firq,
    output logic                    irq_o,
    output logic                    firq_o,
    output logic [NUM_SLOTS-1:0]    irq_status,
    output logic                    timeout_o
);

    localparam int unsigned   CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] FLOAT_W = {DW{FLOAT_DATA[0]}};

    state_e              state_d, state_q;
    logic [SLOT_W-1:0]   slot_n_d, slot_n_q;
    logic                valid_d, valid_q;
    logic [CNT_W-1:0]    min_d, min_q;
    logic [CNT_W-1:0]    cnt_d, cnt_q;
    logic [CNT_W-1:0]    cnt_inc;
    logic [11:0]         slot_adr_d, slot_adr_q;
    logic                slot_we_d, slot_we_q;
    logic [DW-1:0]       slot_dat_o_d, slot_dat_o_q;
    logic [DW-1:0]       wb_dat_o_d, wb_dat_o_q;
    logic                wb_ack_d, wb_ack_q;
    logic                timeout_d, timeout_q;
    logic [NUM_SLOTS-1:0] slot_sel_d, slot_sel_q;
    logic                done_ok, done_to;
    logic [3:0]          ack_ext, present_ext;
    logic [DW-1:0]       rd_slice [4];

    // Unpopulated slot positions read back as floating bus.
    for (genvar k = 0; k < 4; k++) begin : g_slice
        if (k < NUM_SLOTS) begin : g_pop
            assign rd_slice[k] = slot_dat_i[k*DW +: DW];
        end else begin : g_empty
            assign rd_slice[k] = FLOAT_W;
        end
    end

    assign ack_ext     = 4'(slot_ack);
    assign present_ext = 4'(slot_present);
    assign cnt_inc     = cnt_q + 1'b1;
    assign done_ok     = (cnt_inc >= min_q) && (!valid_q || ack_ext[slot_n_q]);
    assign done_to     = cnt_inc >= CNT_W'(TIMEOUT);

    always_comb begin
        state_d      = state_q;
        slot_n_d     = slot_n_q;
        valid_d      = valid_q;
        min_d        = min_q;
        cnt_d        = cnt_q;
        slot_adr_d   = slot_adr_q;
        slot_we_d    = slot_we_q;
        slot_dat_o_d = slot_dat_o_q;
        wb_dat_o_d   = wb_dat_o_q;
        timeout_d    = 1'b0;
        slot_sel_d   = '0;

        case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    state_d      = WAIT;
                    slot_n_d     = wb_adr[13:12];
                    valid_d      = (32'(slot_n_d) < NUM_SLOTS) && present_ext[slot_n_d];
                    slot_adr_d   = wb_adr[11:0];
                    slot_we_d    = wb_we;
                    slot_dat_o_d = wb_dat_i;
                    cnt_d        = '0;
                    case (speed_e'(wb_speed))
                        SPD_SLOW: min_d = CNT_W'(SLOW_CYC);
                        SPD_MED:  min_d = CNT_W'(MED_CYC);
                        SPD_FAST: min_d = CNT_W'(FAST_CYC);
                        SPD_SYNC: min_d = CNT_W'(SYNC_CYC);
                        default:  min_d = CNT_W'(SLOW_CYC);
                    endcase
                end
            end
            WAIT: begin
                if (!wb_cyc) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (done_ok || done_to) begin
                        state_d   = ACK;
                        timeout_d = !done_ok;
                        if (!slot_we_q) begin
                            wb_dat_o_d = (done_ok && valid_q) ? rd_slice[slot_n_q] : FLOAT_W;
                        end
                    end
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (!wb_stb || !wb_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Select and ack are registered alongside the state so they line up with it.
        if (state_d == WAIT && valid_d) begin
            slot_sel_d = NUM_SLOTS'(4'b0001 << slot_n_d);
        end
        wb_ack_d = (state_d == ACK);
    end

    always_ff @(posedge clkcpu) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slot_n_q     <= '0;
            valid_q      <= 1'b0;
            min_q        <= '0;
            cnt_q        <= '0;
            slot_adr_q   <= '0;
            slot_we_q    <= 1'b0;
            slot_dat_o_q <= '0;
            wb_dat_o_q   <= FLOAT_W;
            wb_ack_q     <= 1'b0;
            timeout_q    <= 1'b0;
            slot_sel_q   <= '0;
        end else begin
            state_q      <= state_d;
            slot_n_q     <= slot_n_d;
            valid_q      <= valid_d;
            min_q        <= min_d;
            cnt_q        <= cnt_d;
            slot_adr_q   <= slot_adr_d;
            slot_we_q    <= slot_we_d;
            slot_dat_o_q <= slot_dat_o_d;
            wb_dat_o_q   <= wb_dat_o_d;
            wb_ack_q     <= wb_ack_d;
            timeout_q    <= timeout_d;
            slot_sel_q   <= slot_sel_d;
        end
    end

    assign wb_dat_o   = wb_dat_o_q;
    assign wb_ack     = wb_ack_q;
    assign slot_sel   = slot_sel_q;
    assign slot_we    = slot_we_q;
    assign slot_adr   = slot_adr_q;
    assign slot_dat_o = slot_dat_o_q;
    assign timeout_o  = timeout_q;

    podule_irq_agg #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_irq_agg (
        .clkcpu       (clkcpu),
        .rst_n        (rst_n),
        .slot_irq     (slot_irq),
        .slot_firq    (slot_firq),
        .slot_present (slot_present),
        .irq_o        (irq_o),
        .firq_o       (firq_o),
        .irq_status   (irq_status)
    );

endmodule

// File: tb/tb_podule_bus.sv
// Self-checking bench for podule_bus: directed scenarios plus randomized
// accesses checked against a latency/data model derived from the access rules.
module tb_podule_bus;

    localparam int NS    = 4;
    localparam int DW    = 16;
    localparam int TMO   = 64;
    localparam int NEVER = 1000;

    logic              clkcpu = 1'b0;
    logic              rst_n = 1'b0;
    logic              wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [13:0]       wb_adr = '0;
    logic [1:0]        wb_speed = '0;
    logic [DW-1:0]     wb_dat_i = '0;
    logic [DW-1:0]     wb_dat_o;
    logic              wb_ack;
    logic [NS-1:0]     slot_sel;
    logic              slot_we;
    logic [11:0]       slot_adr;
    logic [DW-1:0]     slot_dat_o;
    logic [NS*DW-1:0]  slot_dat_i = '0;
    logic [NS-1:0]     slot_ack = '0, slot_present = '0, slot_irq = '0, slot_firq = '0;
    logic              irq_o, firq_o, timeout_o;
    logic [NS-1:0]     irq_status;

    podule_bus #(
        .NUM_SLOTS (NS), .DW (DW), .SLOW_CYC (8), .MED_CYC (6),
        .FAST_CYC (4), .SYNC_CYC (2), .TIMEOUT (TMO)
    ) dut (
        .clkcpu (clkcpu), .rst_n (rst_n),
        .wb_cyc (wb_cyc), .wb_stb (wb_stb), .wb_we (wb_we), .wb_adr (wb_adr),
        .wb_speed (wb_speed), .wb_dat_i (wb_dat_i), .wb_dat_o (wb_dat_o), .wb_ack (wb_ack),
        .slot_sel (slot_sel), .slot_we (slot_we), .slot_adr (slot_adr), .slot_dat_o (slot_dat_o),
        .slot_dat_i (slot_dat_i), .slot_ack (slot_ack), .slot_present (slot_present),
        .slot_irq (slot_irq), .slot_firq (slot_firq),
        .irq_o (irq_o), .firq_o (firq_o), .irq_status (irq_status), .timeout_o (timeout_o)
    );

    always #5 clkcpu = ~clkcpu;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] last_rd  = 16'hFFFF;
    int          min_tab [4] = '{8, 6, 4, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_irq();
        chk("irq_o", 32'(irq_o), 32'(|(slot_irq & slot_present)));
        chk("firq_o", 32'(firq_o), 32'(|(slot_firq & slot_present)));
        chk("irq_status", 32'(irq_status), 32'(slot_irq & slot_present));
    endtask

    task automatic chk_reset();
        chk("rst_ack", 32'(wb_ack), 0);
        chk("rst_dat_o", 32'(wb_dat_o), 32'h0000FFFF);
        chk("rst_sel", 32'(slot_sel), 0);
        chk("rst_we", 32'(slot_we), 0);
        chk("rst_adr", 32'(slot_adr), 0);
        chk("rst_sdat", 32'(slot_dat_o), 0);
        chk("rst_irq", 32'(irq_o), 0);
        chk("rst_firq", 32'(firq_o), 0);
        chk("rst_status", 32'(irq_status), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
    endtask

    // Called at a negedge with slot_present/irq already set. The slot's ack
    // is raised at the negedge after edge d, so it is first seen at edge d+1.
    // The access completes at edge c where c = max(min, d+1) for a present
    // slot (capped by the timeout), or c = min for an absent slot.
    task automatic access(input int slot, input bit we, input logic [1:0] spd, input int d);
        int            mn, c, peak;
        bit            valid, ok;
        logic [15:0]   exp_rd, wdata;
        logic [11:0]   sadr;
        logic [NS-1:0] onehot;
        mn    = min_tab[spd];
        valid = slot_present[slot];
        peak  = (d + 1 > mn) ? d + 1 : mn;
        if (!valid) begin
            c = mn; ok = 1'b1;
        end else if (peak <= TMO) begin
            c = peak; ok = 1'b1;
        end else begin
            c = TMO; ok = 1'b0;
        end
        for (int s = 0; s < NS; s++) slot_dat_i[s*DW +: DW] = 16'($urandom);
        wdata  = 16'($urandom);
        sadr   = 12'($urandom);
        onehot = valid ? NS'(1 << slot) : '0;
        exp_rd = we ? last_rd : ((valid && ok) ? slot_dat_i[slot*DW +: DW] : 16'hFFFF);
        slot_ack       = NS'($urandom);
        slot_ack[slot] = (d == 0);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = {2'(slot), sadr}; wb_speed = spd; wb_dat_i = wdata;
        for (int k = 0; k <= c + 1; k++) begin
            @(negedge clkcpu);
            if (k == d && d > 0) slot_ack[slot] = 1'b1;
            if (k == 0) begin
                chk("slot_adr", 32'(slot_adr), 32'(sadr));
                chk("slot_we", 32'(slot_we), 32'(we));
                chk("slot_dat_o", 32'(slot_dat_o), 32'(wdata));
                chk_irq();
            end
            if (k < c) begin
                chk("ack_early", 32'(wb_ack), 0);
                chk("sel_wait", 32'(slot_sel), 32'(onehot));
                chk("timeout_early", 32'(timeout_o), 0);
            end else if (k == c) begin
                chk("ack_done", 32'(wb_ack), 1);
                chk("sel_ack", 32'(slot_sel), 0);
                chk("timeout_done", 32'(timeout_o), 32'(valid && !ok));
                chk("rd_data", 32'(wb_dat_o), 32'(exp_rd));
            end else begin
                chk("ack_once", 32'(wb_ack), 0);
                chk("timeout_once", 32'(timeout_o), 0);
            end
        end
        last_rd = exp_rd;
        wb_cyc = 1'b0; wb_stb = 1'b0; slot_ack = '0;
        @(negedge clkcpu);
        chk("ack_idle", 32'(wb_ack), 0);
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clkcpu);
        chk_reset();
        rst_n = 1'b1;
        @(negedge clkcpu);

        // SYNC read, slot 0, immediate ack
        slot_present = 4'b1111;
        access(0, 1'b0, 2'b11, 0);
        // SLOW write slot 2, ack from cycle 2 -> minimum of 8 still applies
        access(2, 1'b1, 2'b00, 1);
        // FAST read of an absent slot -> floating data, no timeout
        slot_present = 4'b0111;
        access(3, 1'b0, 2'b10, 0);
        // Present slot never acks -> timeout completion
        slot_present = 4'b1111;
        access(1, 1'b0, 2'b00, NEVER);

        // Abort in WAIT, then a clean read
        slot_ack = '0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = {2'd1, 12'h0AB}; wb_speed = 2'b00;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clkcpu);
            if (k <= 3) chk("abort_sel_wait", 32'(slot_sel), 32'(4'b0010));
            if (k == 3) wb_cyc = 1'b0;
            if (k >= 4) chk("abort_sel", 32'(slot_sel), 0);
            chk("abort_ack", 32'(wb_ack), 0);
            chk("abort_timeout", 32'(timeout_o), 0);
        end
        wb_stb = 1'b0;
        @(negedge clkcpu);
        access(0, 1'b0, 2'b11, 0);

        // Interrupt aggregation
        slot_present = 4'b0100; slot_irq = 4'b0110; slot_firq = 4'b1010;
        @(negedge clkcpu);
        chk("irq_set", 32'(irq_o), 1);
        chk("irq_status_set", 32'(irq_status), 32'(4'b0100));
        chk("firq_masked", 32'(firq_o), 0);
        slot_irq[2] = 1'b0; slot_present = 4'b1100;
        @(negedge clkcpu);
        chk("irq_clear", 32'(irq_o), 0);
        chk("irq_status_clear", 32'(irq_status), 0);
        chk("firq_set", 32'(firq_o), 1);

        // Reset mid-WAIT
        slot_present = 4'b1111; slot_irq = 4'b1111; slot_firq = 4'b1111;
        @(negedge clkcpu);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = {2'd2, 12'h123};
        wb_speed = 2'b00; wb_dat_i = 16'hA5A5;
        repeat (2) @(negedge clkcpu);
        rst_n = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clkcpu);
        chk_reset();
        repeat (3) begin
            @(negedge clkcpu);
            chk("rst_hold_ack", 32'(wb_ack), 0);
            chk("rst_hold_timeout", 32'(timeout_o), 0);
        end
        rst_n = 1'b1;
        last_rd = 16'hFFFF;
        @(negedge clkcpu);

        // Randomized accesses
        for (int i = 0; i < 40; i++) begin
            int d;
            slot_present = NS'($urandom);
            slot_irq     = NS'($urandom);
            slot_firq    = NS'($urandom);
            d = ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, 12));
            access(int'($urandom_range(0, NS - 1)), 1'($urandom), 2'($urandom), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
